// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_arbiter
// Description : Round-robin arbiter sharing one SPI mode-0 transmit channel
//               between NUM_REQ requesters. Grants one word at a time and
//               sequences CS assertion, divided SCLK, MSB-first shifting,
//               CS hold and the inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 25,
  parameter int CS_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       spi_cs_l,
  output logic                       spi_sclk,
  output logic                       spi_mosi
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BIT_W = $clog2(WORD_W) + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              r_state,      w_state;
  logic [ID_W-1:0]     r_last_grant, w_last_grant;
  logic [ID_W-1:0]     r_grant_id,   w_grant_id;
  logic [NUM_REQ-1:0]  r_req_ready,  w_req_ready;
  logic [WORD_W-1:0]   r_shift,      w_shift;
  logic [BIT_W-1:0]    r_bit_cnt,    w_bit_cnt;
  logic [DIV_W-1:0]    r_div_cnt,    w_div_cnt;
  logic [GAP_W-1:0]    r_gap_cnt,    w_gap_cnt;
  logic                r_cs_l,       w_cs_l;
  logic                r_sclk,       w_sclk;
  logic                r_mosi,       w_mosi;
  logic                r_frame_done, w_frame_done;
  logic                r_busy,       w_busy;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic                w_arb;
  logic                w_div_last;
  logic [WORD_W-1:0]   w_word;

  // Word offered by the requester whose ready pulse is currently out.
  assign w_word     = req_data[int'(r_grant_id)*WORD_W +: WORD_W];
  assign w_div_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  // Round-robin search starting one past the last granted requester.
  always_comb begin : arb_search
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_last_grant) + i) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  // Next-state and next-output decode; every output leaves through a flop.
  always_comb begin : fsm_next
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant_id   = r_grant_id;
    w_req_ready  = '0;
    w_shift      = r_shift;
    w_bit_cnt    = r_bit_cnt;
    w_div_cnt    = r_div_cnt;
    w_gap_cnt    = r_gap_cnt;
    w_cs_l       = r_cs_l;
    w_sclk       = r_sclk;
    w_mosi       = r_mosi;
    w_frame_done = 1'b0;
    w_arb        = 1'b0;

    case (r_state)
      IDLE: begin
        w_cs_l = 1'b1;
        w_sclk = 1'b0;
        w_mosi = 1'b0;
        // The ready pulse is the grant cycle: the word is taken here.
        if (|r_req_ready) begin
          w_shift   = w_word;
          w_mosi    = w_word[WORD_W-1];
          w_cs_l    = 1'b0;
          w_bit_cnt = '0;
          w_div_cnt = '0;
          w_state   = SHIFT;
        end else begin
          w_arb = 1'b1;
        end
      end

      SHIFT: begin
        if (w_div_last) begin
          w_div_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            // Falling edge: advance data so it is stable for the next rise.
            w_sclk    = 1'b0;
            w_shift   = r_shift << 1;
            w_mosi    = w_shift[WORD_W-1];
            w_bit_cnt = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
              w_state = HOLD;
            end
          end
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (w_div_last) begin
          w_div_cnt    = '0;
          w_cs_l       = 1'b1;
          w_frame_done = 1'b1;
          w_gap_cnt    = '0;
          w_state      = GAP;
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end

      GAP: begin
        // Arbitrate on the last gap cycle so the grant lands on the first
        // idle cycle, CS_GAP cycles after CS rose.
        if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
          w_state = IDLE;
          w_arb   = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_state = IDLE;
        w_cs_l  = 1'b1;
        w_sclk  = 1'b0;
        w_mosi  = 1'b0;
      end
    endcase

    if (w_arb && w_found) begin
      w_req_ready  = NUM_REQ'(1) << w_winner;
      w_grant_id   = w_winner;
      w_last_grant = w_winner;
    end

    w_busy = (w_state != IDLE);
  end

  // State and output registers; asynchronous reset discards any frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_INIT;
      r_grant_id   <= '0;
      r_req_ready  <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_cs_l       <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant_id   <= w_grant_id;
      r_req_ready  <= w_req_ready;
      r_shift      <= w_shift;
      r_bit_cnt    <= w_bit_cnt;
      r_div_cnt    <= w_div_cnt;
      r_gap_cnt    <= w_gap_cnt;
      r_cs_l       <= w_cs_l;
      r_sclk       <= w_sclk;
      r_mosi       <= w_mosi;
      r_frame_done <= w_frame_done;
      r_busy       <= w_busy;
    end
  end

  assign req_ready  = r_req_ready;
  assign grant_id   = r_grant_id;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign spi_cs_l   = r_cs_l;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx_arbiter
// Description : Scoreboard bench for spi_tx_arbiter. Stimulus pushes expected
//               grants and frames; monitors pop and compare on req_ready and
//               frame_done. A second instance uses the fastest divider.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_tx_arbiter;

  localparam int NR        = 4;
  localparam int W         = 16;
  localparam int D         = 25;
  localparam int G         = 2;
  localparam int FRAME_CYC = 1 + (2*W + 1)*D;  // grant to CS rise: 826
  localparam int GRANT_GAP = FRAME_CYC + G;    // grant to next grant: 828

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [1:0]        grant_id;
  logic              busy, frame_done, spi_cs_l, spi_sclk, spi_mosi;

  // Fast-divider instance
  logic              b_rst_n = 1'b0;
  logic [1:0]        b_valid = '0;
  logic [2*W-1:0]    b_data = '0;
  logic [1:0]        b_ready;
  logic [0:0]        b_gid;
  logic              b_busy, b_done, b_cs_l, b_sclk, b_mosi;

  spi_tx_arbiter #(.NUM_REQ(NR), .WORD_W(W), .CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .frame_done(frame_done), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi)
  );

  spi_tx_arbiter #(.NUM_REQ(2), .WORD_W(W), .CLK_DIV(2), .CS_GAP(1)) dut_fast (
    .clk(clk), .reset_n(b_rst_n), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .grant_id(b_gid), .busy(b_busy),
    .frame_done(b_done), .spi_cs_l(b_cs_l), .spi_sclk(b_sclk),
    .spi_mosi(b_mosi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          id;
    logic [15:0] data;
  } frame_t;

  int     exp_grant_q[$];
  frame_t exp_frame_q[$];

  // Grant monitor
  int last_grant_cyc = 0;
  always @(negedge clk) begin
    if (reset_n && req_ready != '0) begin
      int e;
      last_grant_cyc = cyc;
      if (exp_grant_q.size() == 0) begin
        check("unexpected_grant", 32'(req_ready), 32'd0);
      end else begin
        e = exp_grant_q.pop_front();
        check("grant_onehot", 32'(req_ready), 32'(1 << e));
        check("grant_id", 32'(grant_id), 32'(e));
        check("grant_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  // Frame monitor: SPI receiver sampling MOSI on SCLK rise
  logic [15:0] mon_word = '0;
  int          mon_rises = 0;
  int          cs_fall_cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_word  = '0;
      mon_rises = 0;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
    end else begin
      frame_t e;
      if (prev_cs && !spi_cs_l) cs_fall_cyc = cyc;
      if (!prev_sclk && spi_sclk) begin
        mon_word = {mon_word[14:0], spi_mosi};
        mon_rises++;
      end
      if (frame_done) begin
        if (exp_frame_q.size() == 0) begin
          check("unexpected_frame", 32'(mon_word), 32'd0);
        end else begin
          e = exp_frame_q.pop_front();
          check("frame_data", 32'(mon_word), 32'(e.data));
          check("frame_owner", 32'(grant_id), 32'(e.id));
          check("frame_bits", 32'(mon_rises), 32'(W));
          check("frame_cs_high", 32'(spi_cs_l), 32'd1);
          check("frame_done_time", 32'(cyc - last_grant_cyc), 32'(FRAME_CYC));
          check("cs_fall_time", 32'(cs_fall_cyc - last_grant_cyc), 32'd1);
        end
        mon_rises = 0;
        mon_word  = '0;
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_l;
    end
  end

  task automatic set_req(input int id, input logic [15:0] data);
    req_data[id*W +: W] = data;
    req_valid[id]       = 1'b1;
  endtask

  task automatic drop_after_edge(input int id);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_grant(input int id, output int gcyc);
    gcyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) fail($sformatf("grant_wait_id%0d", id));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (exp_grant_q.size() == 0 && exp_frame_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("drain");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Fast-instance bookkeeping
  int          bg[3];
  int          bgn, b_cs_low, b_rises, b_r0, b_r1, b_dones;
  logic        b_prev;
  logic [15:0] b_word;

  initial begin
    int g0, g1, g2, g3, g4;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_l", 32'(spi_cs_l), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    reset_n = 1'b1;

    // Single request from requester 2
    exp_grant_q.push_back(2);
    exp_frame_q.push_back('{id: 2, data: 16'hA5C3});
    set_req(2, 16'hA5C3);
    wait_grant(2, g0);
    drop_after_edge(2);
    drain();

    // All four continuously valid after reset: 0,1,2,3,0
    set_req(0, 16'h1111);
    set_req(1, 16'h2222);
    set_req(2, 16'h4444);
    set_req(3, 16'h8888);
    foreach (exp_grant_q[i]) ;
    for (int i = 0; i < 5; i++) begin
      exp_grant_q.push_back(i % 4);
      exp_frame_q.push_back('{id: i % 4, data: 16'(16'h1111 << (i % 4)) | 16'(16'h1111 << (i % 4)) });
    end
    do_reset();
    wait_grant(0, g0);
    wait_grant(1, g1);
    check("rr_spacing_01", 32'(g1 - g0), 32'(GRANT_GAP));
    wait_grant(2, g2);
    check("rr_spacing_12", 32'(g2 - g1), 32'(GRANT_GAP));
    wait_grant(3, g3);
    check("rr_spacing_23", 32'(g3 - g2), 32'(GRANT_GAP));
    wait_grant(0, g4);
    check("rr_spacing_30", 32'(g4 - g3), 32'(GRANT_GAP));
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    // Requester 3 frame; 0 and 1 arrive mid-frame -> 0 then 1
    exp_grant_q.push_back(3);
    exp_frame_q.push_back('{id: 3, data: 16'h3C96});
    exp_grant_q.push_back(0);
    exp_frame_q.push_back('{id: 0, data: 16'h8001});
    exp_grant_q.push_back(1);
    exp_frame_q.push_back('{id: 1, data: 16'h0F0F});
    set_req(3, 16'h3C96);
    wait_grant(3, g0);
    drop_after_edge(3);
    repeat (200) @(negedge clk);
    set_req(1, 16'h0F0F);
    set_req(0, 16'h8001);
    wait_grant(0, g1);
    check("midframe_first_grant", 32'(g1 - g0), 32'(GRANT_GAP));
    drop_after_edge(0);
    wait_grant(1, g2);
    check("midframe_second_grant", 32'(g2 - g1), 32'(GRANT_GAP));
    drop_after_edge(1);
    drain();

    // One-cycle pulse on requester 1 during a frame is never granted
    exp_grant_q.push_back(2);
    exp_frame_q.push_back('{id: 2, data: 16'h5AA5});
    set_req(2, 16'h5AA5);
    wait_grant(2, g0);
    drop_after_edge(2);
    repeat (100) @(negedge clk);
    set_req(1, 16'hBEEF);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drain();
    repeat (900) @(negedge clk);
    check("pulse_idle_cs_l", 32'(spi_cs_l), 32'd1);
    check("pulse_idle_busy", 32'(busy), 32'd0);

    // Reset at the 8th SCLK rise, then a fresh frame for requester 3
    exp_grant_q.push_back(0);
    set_req(0, 16'hDEAD);
    wait_grant(0, g0);
    drop_after_edge(0);
    while (cyc < g0 + 1 + 15*D) @(negedge clk);
    check("rise8_sclk_high", 32'(spi_sclk), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_cs_l", 32'(spi_cs_l), 32'd1);
    check("midrst_sclk", 32'(spi_sclk), 32'd0);
    check("midrst_mosi", 32'(spi_mosi), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    exp_grant_q.push_back(3);
    exp_frame_q.push_back('{id: 3, data: 16'h1234});
    set_req(3, 16'h1234);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_grant(3, g1);
    drop_after_edge(3);
    drain();

    // Fast divider: CLK_DIV=2, CS_GAP=1, word 0xFFFF held valid
    b_data[15:0] = 16'hFFFF;
    b_valid      = 2'b01;
    bgn = 0; b_cs_low = 0; b_rises = 0; b_r0 = 0; b_r1 = 0; b_dones = 0;
    b_prev = 1'b0; b_word = '0;
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_ready[0]) begin
        if (bgn < 3) bg[bgn] = cyc;
        bgn++;
      end
      if (b_dones == 0) begin
        if (!b_cs_l) b_cs_low++;
        if (!b_prev && b_sclk) begin
          b_word = {b_word[14:0], b_mosi};
          if (b_rises == 0) b_r0 = cyc;
          if (b_rises == 1) b_r1 = cyc;
          b_rises++;
        end
      end
      if (b_done) b_dones++;
      b_prev = b_sclk;
    end
    b_valid = '0;
    check("fast_grants_seen", 32'(bgn >= 3), 32'd1);
    check("fast_grant_spacing1", 32'(bg[1] - bg[0]), 32'd68);
    check("fast_grant_spacing2", 32'(bg[2] - bg[1]), 32'd68);
    check("fast_cs_low_cycles", 32'(b_cs_low), 32'd66);
    check("fast_sclk_period", 32'(b_r1 - b_r0), 32'd4);
    check("fast_rises", 32'(b_rises), 32'd16);
    check("fast_word", 32'(b_word), 32'hFFFF);

    check("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
    check("frame_queue_empty", 32'(exp_frame_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
